// File: rtl/motion_feed_bridge.sv
// Accelerometer-to-renderer bridge: block averaging, dead-band hold
// and a per-frame snapshot handshake with overrun counting.
module motion_feed_bridge #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 16,
  parameter int LOG_AVG  = 2,
  parameter int DEADBAND = 16,
  parameter int OVR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [1:0]               mode,
  input  logic                     frame_sync,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [OVR_W-1:0]         overrun_cnt
);

  localparam int AW   = DATA_W + LOG_AVG;
  localparam int CW   = (LOG_AVG > 0) ? LOG_AVG : 1;
  localparam int NBLK = 1 << LOG_AVG;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBLK - 1);

  typedef enum logic {S_ACC, S_CMP} state_t;

  state_t state_q, state_d;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [AW-1:0]     acc_q  [NUM_CH];
  logic signed [AW-1:0]     acc_d  [NUM_CH];
  logic signed [DATA_W-1:0] avg_q  [NUM_CH];
  logic signed [DATA_W-1:0] avg_d  [NUM_CH];
  logic signed [DATA_W-1:0] held_q [NUM_CH];
  logic signed [DATA_W-1:0] held_d [NUM_CH];

  logic signed [DATA_W-1:0] smp    [NUM_CH];
  logic signed [AW-1:0]     sum    [NUM_CH];
  logic signed [DATA_W-1:0] blkavg [NUM_CH];
  logic signed [DATA_W:0]   diff   [NUM_CH];
  logic        [DATA_W:0]   mag    [NUM_CH];
  logic                     big    [NUM_CH];

  logic [NUM_CH*DATA_W-1:0] held_flat;
  logic [NUM_CH*DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic [OVR_W-1:0]         ovr_q;
  logic                     mode_chg;
  logic                     accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign smp[c]    = in_data[c*DATA_W +: DATA_W];
    assign sum[c]    = acc_q[c] + AW'(smp[c]);
    assign blkavg[c] = DATA_W'(sum[c] >>> LOG_AVG);
    assign diff[c]   = (DATA_W+1)'(avg_q[c]) - (DATA_W+1)'(held_q[c]);
    assign mag[c]    = diff[c][DATA_W] ? -diff[c] : diff[c];
    assign big[c]    = mag[c] > (DATA_W+1)'(DEADBAND);
    assign held_flat[c*DATA_W +: DATA_W] = held_q[c];
  end

  assign mode_chg = (mode != mode_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    avg_d    = avg_q;
    held_d   = held_q;
    in_ready = 1'b0;
    unique case (state_q)
      S_ACC: begin
        in_ready = !rst;
        if (mode_chg || mode_q == 2'b11) begin
          cnt_d = '0;
          for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
        end else if (accept) begin
          if (mode_q == 2'b00) begin
            state_d = S_CMP;
            cnt_d   = '0;
            for (int c = 0; c < NUM_CH; c++) begin
              avg_d[c] = smp[c];
              acc_d[c] = '0;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_CMP;
            cnt_d   = '0;
            for (int c = 0; c < NUM_CH; c++) begin
              avg_d[c] = blkavg[c];
              acc_d[c] = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            for (int c = 0; c < NUM_CH; c++) acc_d[c] = sum[c];
          end
        end
      end
      S_CMP: begin
        state_d = S_ACC;
        // S_CMP uses whichever mode is registered now
        for (int c = 0; c < NUM_CH; c++) begin
          unique case (mode_q)
            2'b00, 2'b01: held_d[c] = avg_q[c];
            2'b10: if (big[c]) held_d[c] = avg_q[c];
            default: held_d[c] = held_q[c];
          endcase
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]  <= '0;
        avg_q[c]  <= '0;
        held_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      held_q  <= held_d;
    end
  end

  // Snapshot takes held_q, so a coincident S_CMP update is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= '0;
    end else if (frame_sync && (!out_valid_q || out_ready)) begin
      out_data_q  <= held_flat;
      out_valid_q <= 1'b1;
    end else if (frame_sync) begin
      if (ovr_q != '1) ovr_q <= ovr_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_motion_feed_bridge.sv
// Directed bench for motion_feed_bridge with hand-computed
// expectations checked by immediate assertions.
module tb_motion_feed_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [1:0]  mode;
  logic        frame_sync;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [7:0]  overrun_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  motion_feed_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .frame_sync (frame_sync),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pk(int a, int b, int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(logic [47:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(logic [47:0] d);
    for (int i = 0; i < 4; i++) send(d);
  endtask

  task automatic block(logic [47:0] d);
    send4(d);
    tick();
  endtask

  task automatic set_mode(logic [1:0] m);
    mode = m;
    tick();
    tick();
  endtask

  task automatic snap(string tag, logic [47:0] exp);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    mode = 2'b01;
    frame_sync = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ovr", 64'(overrun_cnt), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("rel_ready", 64'(in_ready), 64'd1);

    send(pk(4, 4, 4));
    send(pk(8, 8, 8));
    send(pk(12, 12, 12));
    send(pk(16, 16, 16));
    chk("cmp_ready", 64'(in_ready), 64'd0);
    tick();
    chk("cmp_done", 64'(in_ready), 64'd1);
    snap("avg10", pk(10, 10, 10));

    send(pk(-1, 32767, 0));
    send(pk(-2, 32767, 1));
    send(pk(-2, 32767, 2));
    send(pk(-2, 32767, 3));
    tick();
    snap("floor", pk(-2, 32767, 1));

    block(pk(100, 100, 100));
    set_mode(2'b10);
    block(pk(116, 116, 116));
    send4(pk(117, 117, 117));
    snap("coinc", pk(100, 100, 100));
    snap("db117", pk(117, 117, 117));
    block(pk(100, 100, 100));
    snap("dbneg", pk(100, 100, 100));

    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    tick();
    block(pk(300, 300, 300));
    for (int i = 0; i < 2; i++) begin
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
    end
    chk("ovr_cnt", 64'(overrun_cnt), 64'd2);
    chk("ovr_data", 64'(out_data), 64'(pk(100, 100, 100)));
    chk("ovr_valid", 64'(out_valid), 64'd1);
    frame_sync = 1'b1;
    out_ready = 1'b1;
    tick();
    frame_sync = 1'b0;
    out_ready = 1'b0;
    chk("repl_valid", 64'(out_valid), 64'd1);
    chk("repl_data", 64'(out_data), 64'(pk(300, 300, 300)));
    chk("repl_ovr", 64'(overrun_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("repl_drop", 64'(out_valid), 64'd0);

    set_mode(2'b01);
    send(pk(1000, 1000, 1000));
    send(pk(1000, 1000, 1000));
    set_mode(2'b11);
    send4(pk(5000, 5000, 5000));
    chk("frz_ready", 64'(in_ready), 64'd1);
    snap("frz_held", pk(300, 300, 300));
    set_mode(2'b01);
    block(pk(40, 40, 40));
    snap("sw40", pk(40, 40, 40));

    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    send(pk(7, 7, 7));
    send(pk(7, 7, 7));
    rst = 1'b1;
    tick();
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_data", 64'(out_data), 64'd0);
    chk("mrst_ovr", 64'(overrun_cnt), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    block(pk(8, 8, 8));
    snap("post_rst", pk(8, 8, 8));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
